// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and helpers for the FIFO read-side packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Byte width of the async FIFO this stage sits behind
  localparam int DATA_WIDTH = 8;

  // Packer control states
  typedef enum logic [0:0] {
    FILL = 1'b0,  // popping bytes into the accumulator
    XFER = 1'b1   // accumulator waiting for the output register
  } pack_state_e;

  // Lane mask with the lowest cnt bits set
  function automatic logic [31:0] keep_mask(input int unsigned cnt);
    return (32'd1 << cnt) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_out_reg
//  Description : Single-entry valid/ready output register; counts accepted
//                words. A load in the same cycle as an accept keeps the
//                output valid with the new word (back-to-back output).
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_out_reg
  import fifo_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH,
  parameter int Pack       = 4,
  parameter int Cnt_Width  = 16
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst,
  input  logic                       load_i,
  input  logic [Data_Width*Pack-1:0] load_data_i,
  input  logic [Pack-1:0]            load_keep_i,
  output logic                       free_o,
  output logic [Data_Width*Pack-1:0] m_data_o,
  output logic [Pack-1:0]            m_keep_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [Cnt_Width-1:0]       word_cnt_o
);

  logic [Data_Width*Pack-1:0] m_data_q;
  logic [Pack-1:0]            m_keep_q;
  logic                       m_valid_q;
  logic [Cnt_Width-1:0]       word_cnt_q;
  logic                       w_accept;

  assign w_accept   = m_valid_q && m_ready_i;
  // The slot can take a new word if empty or being drained this cycle
  assign free_o     = !m_valid_q || m_ready_i;
  assign m_data_o   = m_data_q;
  assign m_keep_o   = m_keep_q;
  assign m_valid_o  = m_valid_q;
  assign word_cnt_o = word_cnt_q;

  // Hold the word until accepted; count every downstream accept
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_valid_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      if (w_accept) begin
        word_cnt_q <= word_cnt_q + Cnt_Width'(1);
      end
      if (load_i) begin
        m_data_q  <= load_data_i;
        m_keep_q  <= load_keep_i;
        m_valid_q <= 1'b1;
      end else if (w_accept) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_packer
//  Description : Pops bytes from the async FIFO read port and packs Pack of
//                them into one word on a valid/ready interface. A flush
//                emits the current partial word with a lane keep mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH,
  parameter int Pack       = 4,
  parameter int Cnt_Width  = 16
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst,
  input  logic                       empty,
  input  logic [Data_Width-1:0]      data_out,
  output logic                       rd_en,
  input  logic                       flush,
  output logic [Data_Width*Pack-1:0] m_data,
  output logic [Pack-1:0]            m_keep,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [Cnt_Width-1:0]       word_cnt
);

  localparam int AW = $clog2(Pack + 1);

  pack_state_e                state_q, state_d;
  logic [AW-1:0]              acc_cnt_q, acc_cnt_d;
  logic                       inflight_q;
  logic                       flush_pend_q, flush_pend_d;
  logic [Data_Width-1:0]      acc_q [Pack];

  logic [AW:0]                w_occ;
  logic                       w_out_free;
  logic                       w_xfer;
  logic [Data_Width*Pack-1:0] w_word;
  logic [Pack-1:0]            w_keep;

  // Occupancy counts the byte still in flight so we never overrun a lane
  assign w_occ  = {1'b0, acc_cnt_q} + (AW+1)'(inflight_q);
  assign rd_en  = !rd_rst && !empty && !flush_pend_q && (w_occ < (AW+1)'(Pack));
  assign w_xfer = (state_q == XFER) && w_out_free;
  assign w_keep = Pack'(keep_mask(32'(acc_cnt_q)));

  // Unfilled lanes are forced to zero so a partial word carries no stale data
  for (genvar i = 0; i < Pack; i++) begin : g_lane
    assign w_word[i*Data_Width +: Data_Width] = (AW'(i) < acc_cnt_q) ? acc_q[i] : '0;
  end

  // Next-state for fill count, flush request and control state
  always_comb begin
    acc_cnt_d    = acc_cnt_q;
    flush_pend_d = flush_pend_q;
    state_d      = state_q;

    if (w_xfer) begin
      acc_cnt_d = '0;
    end else if (inflight_q) begin
      acc_cnt_d = acc_cnt_q + AW'(1);
    end

    // A flush with nothing accumulated or in flight is dropped
    if (flush && ((acc_cnt_q != '0) || inflight_q)) begin
      flush_pend_d = 1'b1;
    end
    if (w_xfer) begin
      flush_pend_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        // Look at the post-capture count so a full word moves one cycle sooner
        if ((acc_cnt_d == AW'(Pack)) ||
            (flush_pend_q && !inflight_q && (acc_cnt_q != '0))) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (w_xfer) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Control registers and byte capture into the next free lane
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q      <= FILL;
      acc_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      for (int i = 0; i < Pack; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      inflight_q   <= rd_en;
      flush_pend_q <= flush_pend_d;
      for (int i = 0; i < Pack; i++) begin
        if (inflight_q && (acc_cnt_q == AW'(i))) begin
          acc_q[i] <= data_out;
        end
      end
    end
  end

  fifo_rd_out_reg #(
    .Data_Width (Data_Width),
    .Pack       (Pack),
    .Cnt_Width  (Cnt_Width)
  ) u_out_reg (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .load_i      (w_xfer),
    .load_data_i (w_word),
    .load_keep_i (w_keep),
    .free_o      (w_out_free),
    .m_data_o    (m_data),
    .m_keep_o    (m_keep),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .word_cnt_o  (word_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_packer
//  Description : Self-checking bench for fifo_rd_packer with a FIFO read-port
//                model and an output word scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int CW = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          empty;
  logic [DW-1:0] data_out = '0;
  logic          rd_en;
  logic          flush = 1'b0;
  logic [DW*PK-1:0] m_data;
  logic [PK-1:0] m_keep;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] word_cnt;

  int checks = 0;
  int errors = 0;

  // FIFO model storage; stimulus owns wr_ptr, the read model owns rd_ptr
  logic [7:0] mem [4096];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       gate_empty = 1'b0;
  logic       pop_ok = 1'b0;
  int         rden_cnt = 0;
  int         rx_cnt = 0;

  logic [31:0] exp_data_q [$];
  logic [3:0]  exp_keep_q [$];

  assign empty = gate_empty || (wr_ptr == rd_ptr);

  fifo_rd_packer #(
    .Data_Width (DW),
    .Pack       (PK),
    .Cnt_Width  (CW)
  ) dut (
    .rd_clk   (rd_clk),
    .rd_rst   (rd_rst),
    .empty    (empty),
    .data_out (data_out),
    .rd_en    (rd_en),
    .flush    (flush),
    .m_data   (m_data),
    .m_keep   (m_keep),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .word_cnt (word_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[11:0]] = b;
    wr_ptr++;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
    exp_data_q.push_back(d);
    exp_keep_q.push_back(k);
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rx_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, rx_cnt, n);
  endtask

  // FIFO read port: data appears one cycle after an accepted rd_en
  always @(posedge rd_clk) begin
    if (pop_ok) begin
      data_out <= mem[rd_ptr[11:0]];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // Mid-cycle monitor: pop safety, pop counting, scoreboard on handshake
  always @(negedge rd_clk) begin
    logic [31:0] ed;
    logic [3:0]  ek;
    pop_ok = rd_en;
    if (rd_en) rden_cnt++;
    check("rd_en_while_empty", rd_en && empty, 0);
    if (m_valid && m_ready) begin
      if (exp_data_q.size() == 0) begin
        check("unexpected_word", m_data, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        ed = exp_data_q.pop_front();
        ek = exp_keep_q.pop_front();
        check("m_data", m_data, ed);
        check("m_keep", m_keep, ek);
      end
      rx_cnt++;
    end
  end

  initial begin
    int r0;
    int k;
    logic [31:0] w;
    logic [7:0]  b;

    // Reset state
    rd_rst = 1'b1;
    tick(3);
    check("rst_rd_en", rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_keep", m_keep, 0);
    check("rst_word_cnt", word_cnt, 0);
    rd_rst = 1'b0;
    tick();

    // Full word with ready downstream
    m_ready = 1'b1;
    r0 = rden_cnt;
    expect_word(32'h44332211, 4'hF);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_rx(1, 50, "t1_rx");
    tick(2);
    check("t1_rd_en_pulses", rden_cnt - r0, 4);
    check("t1_word_cnt", word_cnt, 1);

    // Backpressure: first word holds, second word waits in accumulator
    m_ready = 1'b0;
    r0 = rden_cnt;
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(30);
    check("t2_m_valid", m_valid, 1);
    check("t2_m_data_hold", m_data, 32'h04030201);
    check("t2_m_keep_hold", m_keep, 4'hF);
    check("t2_rd_en_blocked", rd_en, 0);
    check("t2_pops", rden_cnt - r0, 8);
    tick(5);
    check("t2_m_data_stable", m_data, 32'h04030201);
    check("t2_rx_hold", rx_cnt, 1);
    m_ready = 1'b1;
    wait_rx(3, 50, "t2_rx");
    tick(2);
    check("t2_word_cnt", word_cnt, 3);

    // Partial word through flush; no pops while the flush is pending
    push(8'hAA); push(8'hBB); push(8'hCC);
    tick(10);
    r0 = rden_cnt;
    expect_word(32'h00CCBBAA, 4'b0111);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push(8'hDD);
    k = 0;
    while (!m_valid && k < 20) begin
      tick();
      k++;
    end
    check("t3_valid", m_valid, 1);
    check("t3_no_pop_before_xfer", rden_cnt - r0, 0);
    wait_rx(4, 20, "t3_rx");
    tick(5);
    expect_word(32'h000000DD, 4'b0001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_rx(5, 30, "t3_dd_rx");
    tick(2);
    check("t3_word_cnt", word_cnt, 5);

    // Flush with nothing accumulated is ignored
    tick(5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(10);
    check("t4_m_valid", m_valid, 0);
    check("t4_word_cnt", word_cnt, 5);
    check("t4_rx", rx_cnt, 5);

    // Random backpressure with empty toggling; byte order must be preserved
    w = '0;
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom_range(0, 255));
      push(b);
      w[8*(i%4) +: 8] = b;
      if ((i % 4) == 3) expect_word(w, 4'hF);
    end
    for (int c = 0; c < 1000; c++) begin
      gate_empty = ~gate_empty;
      m_ready    = 1'($urandom_range(0, 1));
      tick();
    end
    gate_empty = 1'b0;
    m_ready    = 1'b1;
    wait_rx(80, 800, "t5_rx");
    tick(2);
    check("t5_word_cnt", word_cnt, 80);

    // Reset mid-word discards accumulated bytes
    push(8'h77); push(8'h88);
    tick(6);
    rd_rst = 1'b1;
    tick();
    check("t6_rst_rd_en", rd_en, 0);
    check("t6_rst_m_valid", m_valid, 0);
    check("t6_rst_m_data", m_data, 0);
    check("t6_rst_m_keep", m_keep, 0);
    check("t6_rst_word_cnt", word_cnt, 0);
    rd_rst = 1'b0;
    tick();
    expect_word(32'h04030201, 4'hF);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_rx(81, 50, "t6_rx");
    tick(2);
    check("t6_word_cnt", word_cnt, 1);
    check("sb_drained", exp_data_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
